// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared FSM encoding and defaults for the systolic subarray scheduler
package systolic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_e;

    localparam int DEFAULT_TIMEOUT = 1024;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or above ptr, wrapping
module rr_arbiter
    import systolic_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx,
    output logic               grant_any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && req[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
            cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/subarray_scheduler.sv
// rtl/subarray_scheduler.sv - shares one systolic subarray among NUM_REQ requesters with a watchdog
module subarray_scheduler
    import systolic_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT,
    localparam int ID_W      = id_width(NUM_REQ),
    localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic                          clk,
    input  logic                          srstn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_w,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_d,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tpu_start,
    input  logic                          tpu_done,
    output logic [ADDR_WIDTH-1:0]         cfg_base_w,
    output logic [ADDR_WIDTH-1:0]         cfg_base_d,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_error
);

    sched_state_e          state;
    logic [ID_W-1:0]       rr_ptr;
    logic [CNT_W-1:0]      wd_cnt;
    logic                  err;
    logic [NUM_REQ-1:0]    win_grant;
    logic [ID_W-1:0]       win_idx;
    logic                  win_any;
    logic [ADDR_WIDTH-1:0] win_base_w;
    logic [ADDR_WIDTH-1:0] win_base_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (win_grant),
        .grant_idx (win_idx),
        .grant_any (win_any)
    );

    always_comb begin
        win_base_w = '0;
        win_base_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == ID_W'(i)) begin
                win_base_w = req_base_w[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_base_d = req_base_d[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign req_ready = (state == ST_IDLE && !srstn) ? win_grant : '0;
    assign rsp_error = err & (state == ST_RESP);

    always_ff @(posedge clk) begin
        if (srstn) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            wd_cnt     <= '0;
            err        <= 1'b0;
            grant_id   <= '0;
            cfg_base_w <= '0;
            cfg_base_d <= '0;
            tpu_start  <= 1'b0;
            rsp_valid  <= '0;
            busy       <= 1'b0;
        end else begin
            tpu_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (win_any) begin
                        grant_id   <= win_idx;
                        cfg_base_w <= win_base_w;
                        cfg_base_d <= win_base_d;
                        rr_ptr     <= (win_idx == ID_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                        tpu_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end
                ST_START: begin
                    wd_cnt <= '0;
                    state  <= ST_RUN;
                end
                ST_RUN: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    // completion wins over a simultaneous watchdog expiry
                    if (tpu_done) begin
                        err       <= 1'b0;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= ST_RESP;
                    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err       <= 1'b1;
                        rsp_valid <= NUM_REQ'(1) << grant_id;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subarray_scheduler.sv
// tb/tb_subarray_scheduler.sv - directed and randomized bench for subarray_scheduler with a job-timeline model
module tb_subarray_scheduler;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          srstn;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_base_w;
    logic [N*AW-1:0] req_base_d;
    logic [N-1:0]  req_ready;
    logic          tpu_start;
    logic          tpu_done;
    logic [AW-1:0] cfg_base_w;
    logic [AW-1:0] cfg_base_d;
    logic [1:0]    grant_id;
    logic          busy;
    logic [N-1:0]  rsp_valid;
    logic          rsp_error;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    subarray_scheduler #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk        (clk),
        .srstn      (srstn),
        .req_valid  (req_valid),
        .req_base_w (req_base_w),
        .req_base_d (req_base_d),
        .req_ready  (req_ready),
        .tpu_start  (tpu_start),
        .tpu_done   (tpu_done),
        .cfg_base_w (cfg_base_w),
        .cfg_base_d (cfg_base_d),
        .grant_id   (grant_id),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_error  (rsp_error)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) begin
            t = v >> ((p + k) % N);
            if (t[0]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i < 0) ? '0 : (N'(1) << i);
    endfunction

    // Job-timeline model: accept at cycle a, START at a+1, RUN from a+2, response one cycle after done/expiry.
    bit            m_init = 0;
    bit            m_act  = 0;
    bit            m_err  = 0;
    int            m_acc  = 0;
    int            m_gid  = 0;
    int            m_ptr  = 0;
    int            m_rsp_at = -1;
    int            m_cyc  = 0;
    int            m_w;
    logic [AW-1:0] m_bw = '0;
    logic [AW-1:0] m_bd = '0;
    bit            m_in_rsp;

    initial forever begin
        @(negedge clk);
        #2;
        if (m_init) begin
            m_w = pick(req_valid, m_ptr);
            m_in_rsp = m_act && (m_cyc == m_rsp_at);
            check("m_req_ready", 32'(req_ready), 32'((!srstn && !m_act) ? oh(m_w) : '0));
            check("m_busy", 32'(busy), 32'(m_act));
            check("m_tpu_start", 32'(tpu_start), 32'(m_act && (m_cyc == m_acc + 1)));
            check("m_rsp_valid", 32'(rsp_valid), 32'(m_in_rsp ? oh(m_gid) : '0));
            check("m_rsp_error", 32'(rsp_error), 32'(m_in_rsp && m_err));
            check("m_grant_id", 32'(grant_id), 32'(m_gid));
            check("m_cfg_base_w", 32'(cfg_base_w), 32'(m_bw));
            check("m_cfg_base_d", 32'(cfg_base_d), 32'(m_bd));
        end
        if (srstn) begin
            m_init = 1; m_act = 0; m_ptr = 0; m_gid = 0;
            m_bw = '0; m_bd = '0; m_rsp_at = -1; m_err = 0;
        end else if (m_init) begin
            if (!m_act) begin
                m_w = pick(req_valid, m_ptr);
                if (m_w >= 0) begin
                    m_act = 1; m_acc = m_cyc; m_gid = m_w; m_rsp_at = -1;
                    m_bw = req_base_w[m_w*AW +: AW];
                    m_bd = req_base_d[m_w*AW +: AW];
                    m_ptr = (m_w + 1) % N;
                end
            end else if (m_rsp_at < 0) begin
                if (m_cyc >= m_acc + 2) begin
                    if (tpu_done) begin
                        m_rsp_at = m_cyc + 1; m_err = 0;
                    end else if (m_cyc - (m_acc + 2) == TO - 1) begin
                        m_rsp_at = m_cyc + 1; m_err = 1;
                    end
                end
            end else if (m_cyc == m_rsp_at) begin
                m_act = 0;
            end
        end
        m_cyc++;
    end

    task automatic wait_start(output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (tpu_start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_start: no tpu_start within 40 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL wait_idle: busy still high after 40 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        bit   ok;
        int   got[8];
        time  ts[8];
        int   n;

        srstn = 1'b1; req_valid = '0; req_base_w = '0; req_base_d = '0; tpu_done = 1'b0;
        repeat (2) @(negedge clk);
        srstn = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_tpu_start", 32'(tpu_start), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);

        // single request from requester 1
        @(negedge clk);
        req_valid = 4'b0010;
        req_base_w[AW +: AW] = 10'h040;
        req_base_d[AW +: AW] = 10'h080;
        #3;
        check("t1_req_ready", 32'(req_ready), 32'h2);
        @(negedge clk);
        req_valid = '0;
        #3;
        check("t1_tpu_start", 32'(tpu_start), 1);
        check("t1_cfg_w", 32'(cfg_base_w), 32'h040);
        check("t1_cfg_d", 32'(cfg_base_d), 32'h080);
        check("t1_grant_id", 32'(grant_id), 1);
        repeat (10) @(negedge clk);
        tpu_done = 1'b1;
        @(negedge clk);
        tpu_done = 1'b0;
        #3;
        check("t1_rsp_valid", 32'(rsp_valid), 32'h2);
        check("t1_rsp_error", 32'(rsp_error), 0);
        @(negedge clk);
        #3;
        check("t1_idle", 32'(busy), 0);

        // fairness with all requesters active
        @(negedge clk); srstn = 1'b1;
        @(negedge clk); srstn = 1'b0; req_valid = 4'b1111; tpu_done = 1'b1;
        for (int j = 0; j < 8; j++) begin
            wait_start(ok);
            got[j] = int'(grant_id);
            ts[j]  = $time;
        end
        @(negedge clk); req_valid = '0;
        wait_idle();
        tpu_done = 1'b0;
        for (int j = 0; j < 8; j++) check("fair_order", 32'(got[j]), 32'(j % 4));
        check("fair_spacing", 32'((ts[1] - ts[0]) / 10), 4);
        check("fair_spacing_last", 32'((ts[7] - ts[6]) / 10), 4);

        // watchdog expiry
        @(negedge clk); req_valid = 4'b0001;
        @(negedge clk); req_valid = '0;
        #3;
        check("to_start", 32'(tpu_start), 1);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #3;
            n++;
            if (rsp_valid != '0) break;
        end
        check("to_run_cycles", 32'(n - 1), 16);
        check("to_rsp_valid", 32'(rsp_valid), 32'h1);
        check("to_rsp_error", 32'(rsp_error), 1);
        @(negedge clk);
        #3;
        check("to_idle", 32'(busy), 0);

        // done on the last RUN cycle beats expiry
        @(negedge clk); req_valid = 4'b0010;
        @(negedge clk); req_valid = '0;
        #3;
        check("bd_start", 32'(tpu_start), 1);
        repeat (16) @(negedge clk);
        tpu_done = 1'b1;
        @(negedge clk);
        tpu_done = 1'b0;
        #3;
        check("bd_rsp_valid", 32'(rsp_valid), 32'h2);
        check("bd_rsp_error", 32'(rsp_error), 0);
        @(negedge clk); tpu_done = 1'b1;
        @(negedge clk);
        #3;
        check("spur_busy", 32'(busy), 0);
        check("spur_start", 32'(tpu_start), 0);
        @(negedge clk); tpu_done = 1'b0;

        // reset in the middle of a job
        @(negedge clk); req_valid = 4'b1000; req_base_w[3*AW +: AW] = 10'h3c0;
        @(negedge clk); req_valid = '0;
        #3;
        check("rm_start", 32'(tpu_start), 1);
        check("rm_grant", 32'(grant_id), 3);
        repeat (3) @(negedge clk);
        @(negedge clk); srstn = 1'b1; req_valid = 4'b0100;
        #3;
        check("rm_ready_in_reset", 32'(req_ready), 0);
        @(negedge clk); srstn = 1'b0;
        #3;
        check("rm_busy", 32'(busy), 0);
        check("rm_grant_clr", 32'(grant_id), 0);
        check("rm_cfg_clr", 32'(cfg_base_w), 0);
        check("rm_rsp", 32'(rsp_valid), 0);
        check("rm_ready", 32'(req_ready), 32'h4);
        @(negedge clk); req_valid = '0;
        #3;
        check("rm_regrant", 32'(grant_id), 2);
        @(negedge clk); tpu_done = 1'b1;
        @(negedge clk); tpu_done = 1'b0;
        #3;
        check("rm_rsp_after", 32'(rsp_valid), 32'h4);

        // pointer wrap from 3 to 0
        @(negedge clk); req_valid = 4'b1001; tpu_done = 1'b1;
        @(negedge clk);
        #3;
        check("wr_first", 32'(grant_id), 3);
        wait_start(ok);
        check("wr_second", 32'(grant_id), 0);
        @(negedge clk); req_valid = '0;
        wait_idle();
        tpu_done = 1'b0;

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            srstn      = ($urandom_range(0, 99) == 0);
            req_valid  = N'($urandom);
            req_base_w = (N*AW)'({$urandom(), $urandom()});
            req_base_d = (N*AW)'({$urandom(), $urandom()});
            tpu_done   = ($urandom_range(0, 5) == 0);
        end
        @(negedge clk);
        srstn = 1'b0; req_valid = '0; tpu_done = 1'b0;
        repeat (25) @(negedge clk);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/subarray_scheduler.md
SUBARRAY_SCHEDULER -- requirements
Module: subarray_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one systolic subarray.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the SRAM base-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the maximum RUN cycles before abort.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 srstn  input  1  reset; synchronous, active-high.
REQ-006 req_valid  input  NUM_REQ  per-requester job request.
REQ-007 req_base_w  input  NUM_REQ*ADDR_WIDTH  per-requester weight base address; slice i belongs to requester i.
REQ-008 req_base_d  input  NUM_REQ*ADDR_WIDTH  per-requester data base address; slice i belongs to requester i.
REQ-009 req_ready  output  NUM_REQ  one-hot accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-010 tpu_start  output  1  one-cycle start pulse to the subarray.
REQ-011 tpu_done  input  1  completion pulse from the subarray.
REQ-012 cfg_base_w, cfg_base_d  output  ADDR_WIDTH each  base addresses of the granted job.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the granted requester.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 rsp_valid  output  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-016 rsp_error  output  1  qualifies rsp_valid; 1 = timed out.

Function
REQ-017 The FSM SHALL have states IDLE, START, RUN and RESP.
REQ-018 In IDLE with any req_valid high, req_ready SHALL be the one-hot winner, combinational in the same cycle; otherwise req_ready SHALL be 0.
REQ-019 The winner SHALL be the first requester with req_valid high, searching from rr_ptr upward with wrap from NUM_REQ-1 to 0.
REQ-020 On the accepting edge the block SHALL capture the winner into grant_id and capture its bases into cfg_base_w/cfg_base_d, set rr_ptr to winner+1 (mod NUM_REQ), and go to START.
REQ-021 cfg_base_w, cfg_base_d and grant_id SHALL hold until the next accept.
REQ-022 START SHALL last exactly 1 cycle with tpu_start=1, then go to RUN; tpu_start SHALL be 0 in all other states.
REQ-023 In RUN the watchdog counter SHALL increment each cycle from 0.
REQ-024 In RUN, tpu_done=1 SHALL go to RESP with error=0.
REQ-025 In RUN, a counter value of TIMEOUT-1 with tpu_done=0 SHALL go to RESP with error=1.
REQ-026 In RUN, tpu_done=1 in the same cycle as the counter reaching TIMEOUT-1 SHALL give error=0.
REQ-027 RESP SHALL last 1 cycle with rsp_valid[grant_id]=1 and rsp_error set to the captured error, then return to IDLE.
REQ-028 rsp_error SHALL be 0 whenever rsp_valid is 0.
REQ-029 tpu_done SHALL be ignored outside RUN.
REQ-030 Changes to req_valid outside IDLE SHALL have no effect.
REQ-031 Minimum accept-to-accept spacing SHALL be 4 cycles (IDLE, START, at least one RUN cycle, RESP).
REQ-032 Minimum accept-to-rsp latency SHALL be 3 cycles.

Reset
REQ-033 When srstn=1 at a clock edge, the block SHALL go to IDLE from any state, including mid-RUN.
REQ-034 On that reset edge, rr_ptr, the watchdog counter, grant_id, cfg_base_w, cfg_base_d and the error flag SHALL be cleared to 0.
REQ-035 On that reset edge, tpu_start, rsp_valid, rsp_error and busy SHALL be cleared to 0.
REQ-036 An aborted job SHALL produce no rsp_valid.
REQ-037 req_ready SHALL be 0 while srstn=1.

Structure
REQ-038 FSM state encoding and a default TIMEOUT constant SHALL live in the shared package systolic_pkg.
REQ-039 The block SHALL use one sub-module, rr_arbiter (NUM_REQ request vector + pointer -> one-hot grant + index), which is purely combinational.
REQ-040 Exactly one FSM and one watchdog counter SHALL be implemented, both in subarray_scheduler.

Verification
REQ-041 Single request: req_valid=4'b0010, base_w=0x040, base_d=0x080, tpu_done 10 cycles after start -> req_ready=0010, tpu_start 1 cycle later, cfg=0x040/0x080, grant_id=1, rsp_valid=0010, rsp_error=0.
REQ-042 Fairness: all four req_valid held high through 8 jobs -> grant order 0,1,2,3,0,1,2,3.
REQ-043 Timeout: TIMEOUT=16, tpu_done never asserted -> rsp_valid pulses exactly 16 RUN cycles after entry, rsp_error=1, then IDLE.
REQ-044 Boundary: tpu_done on the 16th RUN cycle (TIMEOUT=16) -> rsp_error=0; a spurious tpu_done in IDLE -> no state change.
REQ-045 Reset mid-RUN: srstn=1 for 1 cycle -> next cycle busy=0 and all outputs 0, no rsp_valid; a pending req_valid=0100 is then accepted as grant_id=2.
REQ-046 Wrap: rr_ptr=3, req_valid=1001 -> grant 3, then grant 0.
